// File: rtl/i2s_adc_ctrl.sv
// ---------------------------------------------------------------------------
// i2s_adc_ctrl
//   I2S master controller for a stereo ADC. Derives bclk/lrclk from clk_i,
//   deserialises sdata_i into left/right samples, and presents finished
//   frames to the mixer through a valid/ack handshake. Frames that land on
//   an unacknowledged predecessor overwrite it and set a sticky overrun flag.
//
// Ports
//   clk_i          system clock (the only clock)
//   rst_n_i        asynchronous active-low reset
//   en_i           run enable; low parks the clock generator and drops any
//                  partial frame, but keeps the last outputs and handshake
//   sdata_i        ADC serial data, sampled on bclk rising edges
//   sample_ack_i   consumer acknowledge for sample_valid_o
//   ovr_clr_i      clears overrun_o (a simultaneous new overrun wins)
//   bclk_o         bit clock, registered
//   lrclk_o        word select, registered; 0 = left slot, 1 = right slot
//   left_chan_o    last completed left sample, MSB-first two's complement
//   right_chan_o   last completed right sample
//   sample_valid_o a completed frame is pending
//   overrun_o      sticky: a frame completed while one was still pending
// ---------------------------------------------------------------------------
module i2s_adc_ctrl #(
    parameter int AUDIO_DW  = 16,
    parameter int SLOT_BITS = 32,
    parameter int DIV       = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic                sdata_i,
    input  logic                sample_ack_i,
    input  logic                ovr_clr_i,
    output logic                bclk_o,
    output logic                lrclk_o,
    output logic [AUDIO_DW-1:0] left_chan_o,
    output logic [AUDIO_DW-1:0] right_chan_o,
    output logic                sample_valid_o,
    output logic                overrun_o
);

    localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(2 * SLOT_BITS);

    localparam logic [HW-1:0] HCNT_MAX = HW'(DIV - 1);
    localparam logic [BW-1:0] BIT_MAX  = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);
    localparam logic [BW-1:0] POS_LAST = BW'(AUDIO_DW);

    logic [HW-1:0]       hcnt_q,   hcnt_d;
    logic                bclk_q,   bclk_d;
    logic [BW-1:0]       bitcnt_q, bitcnt_d;
    logic                lrclk_q,  lrclk_d;
    logic [AUDIO_DW-1:0] sh_l_q,   sh_l_d;
    logic [AUDIO_DW-1:0] sh_r_q,   sh_r_d;
    logic [AUDIO_DW-1:0] left_q,   left_d;
    logic [AUDIO_DW-1:0] right_q,  right_d;
    logic                valid_q,  valid_d;
    logic                ovr_q,    ovr_d;

    logic                tick, rise_evt, fall_evt, cap, frame_done;
    logic [BW-1:0]       pos;
    logic [AUDIO_DW-1:0] sh_l_next, sh_r_next;

    // bclk toggles when the half-period divider wraps; the direction of the
    // toggle tells us whether this edge is a rise or a fall event.
    assign tick     = en_i && (hcnt_q == HCNT_MAX);
    assign rise_evt = tick && !bclk_q;
    assign fall_evt = tick &&  bclk_q;

    // lrclk_q always equals (bitcnt_q >= SLOT_BITS), so it selects the slot.
    assign pos = lrclk_q ? (bitcnt_q - SLOT) : bitcnt_q;

    // pos 0 is the I2S one-bit delay; only pos 1..AUDIO_DW carry sample data.
    assign cap        = rise_evt && (pos != '0) && (pos <= POS_LAST);
    assign frame_done = rise_evt && lrclk_q && (pos == POS_LAST);

    assign sh_l_next = (sh_l_q << 1) | AUDIO_DW'(sdata_i);
    assign sh_r_next = (sh_r_q << 1) | AUDIO_DW'(sdata_i);

    always_comb begin
        hcnt_d   = hcnt_q;
        bclk_d   = bclk_q;
        bitcnt_d = bitcnt_q;
        lrclk_d  = lrclk_q;
        sh_l_d   = sh_l_q;
        sh_r_d   = sh_r_q;
        left_d   = left_q;
        right_d  = right_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;

        if (!en_i) begin
            // Park so a later enable restarts cleanly at bitcnt 0, bclk 0.
            hcnt_d   = '0;
            bclk_d   = 1'b0;
            bitcnt_d = '0;
            lrclk_d  = 1'b0;
            sh_l_d   = '0;
            sh_r_d   = '0;
        end else begin
            hcnt_d = tick ? '0 : hcnt_q + 1'b1;
            if (tick) begin
                bclk_d = ~bclk_q;
            end
            if (fall_evt) begin
                bitcnt_d = (bitcnt_q == BIT_MAX) ? '0 : bitcnt_q + 1'b1;
                lrclk_d  = (bitcnt_d >= SLOT);
            end
            if (cap) begin
                if (lrclk_q) begin
                    sh_r_d = sh_r_next;
                end else begin
                    sh_l_d = sh_l_next;
                end
            end
        end

        // Handshake keeps working while disabled.
        if (valid_q && sample_ack_i) begin
            valid_d = 1'b0;
        end
        // A completing frame re-asserts valid even if acked on this edge.
        if (frame_done) begin
            left_d  = sh_l_q;
            right_d = sh_r_next;
            valid_d = 1'b1;
        end

        if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end
        if (frame_done && valid_q && !sample_ack_i) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hcnt_q   <= '0;
            bclk_q   <= 1'b0;
            bitcnt_q <= '0;
            lrclk_q  <= 1'b0;
            sh_l_q   <= '0;
            sh_r_q   <= '0;
            left_q   <= '0;
            right_q  <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            bclk_q   <= bclk_d;
            bitcnt_q <= bitcnt_d;
            lrclk_q  <= lrclk_d;
            sh_l_q   <= sh_l_d;
            sh_r_q   <= sh_r_d;
            left_q   <= left_d;
            right_q  <= right_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bclk_o         = bclk_q;
    assign lrclk_o        = lrclk_q;
    assign left_chan_o    = left_q;
    assign right_chan_o   = right_q;
    assign sample_valid_o = valid_q;
    assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_i2s_adc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2s_adc_ctrl
//   Directed timeline against i2s_adc_ctrl with default parameters. An ADC
//   model drives sdata on every observed bclk fall from a table of frames
//   (directed words first, $urandom words after, random filler bits in the
//   unused slot positions). Expected timing comes from the frame arithmetic:
//   with en seen from edge 1, frame k completes at edge 388 + 512*k.
// ---------------------------------------------------------------------------
module tb_i2s_adc_ctrl;

    localparam int DW  = 16;
    localparam int SB  = 32;
    localparam int DIV = 4;
    localparam int NF  = 16;

    logic          clk, rst_n, en, sdata, ack, ovr_clr;
    logic          bclk_o, lrclk_o, valid_o, ovr_o;
    logic [DW-1:0] left_o, right_o;

    logic [DW-1:0] fl [NF];
    logic [DW-1:0] fr [NF];

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;
    int fnum = 0;

    i2s_adc_ctrl #(.AUDIO_DW(DW), .SLOT_BITS(SB), .DIV(DIV)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .en_i          (en),
        .sdata_i       (sdata),
        .sample_ack_i  (ack),
        .ovr_clr_i     (ovr_clr),
        .bclk_o        (bclk_o),
        .lrclk_o       (lrclk_o),
        .left_chan_o   (left_o),
        .right_chan_o  (right_o),
        .sample_valid_o(valid_o),
        .overrun_o     (ovr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk_frame(input string tag, input int k, input logic v, input logic ov);
        chk({tag, "_valid"}, 32'(valid_o), 32'(v));
        chk({tag, "_ovr"},   32'(ovr_o),   32'(ov));
        chk({tag, "_left"},  32'(left_o),  32'(fl[k]));
        chk({tag, "_right"}, 32'(right_o), 32'(fr[k]));
    endtask

    // bclk rises DIV edges after enable and toggles every DIV edges after.
    function automatic logic exp_bclk(input int c);
        return (c >= DIV) && ((((c - DIV) / DIV) % 2) == 0);
    endfunction

    // Bit index advances once per bclk period (2*DIV edges); right slot is
    // the upper half of the 2*SB-bit frame.
    function automatic logic exp_lrclk(input int c);
        return ((c / (2 * DIV)) % (2 * SB)) >= SB;
    endfunction

    // ADC model: starts a new frame word pair when enabled and every 2*SB
    // bclk falls; after each fall drives the bit for the new slot position.
    initial begin : adc
        int            falls, idx, pos;
        logic          prev_b, active;
        logic [DW-1:0] cl, cr;
        sdata  = 1'b0;
        falls  = 0;
        prev_b = 1'b0;
        active = 1'b0;
        cl     = '0;
        cr     = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n || !en) begin
                active = 1'b0;
                falls  = 0;
                prev_b = 1'b0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    cl = fl[fnum % NF];
                    cr = fr[fnum % NF];
                    fnum++;
                end
                if (prev_b && !bclk_o) begin
                    falls++;
                    idx = falls % (2 * SB);
                    if (idx == 0) begin
                        cl = fl[fnum % NF];
                        cr = fr[fnum % NF];
                        fnum++;
                    end
                    chk("lrclk_at_fall", 32'(lrclk_o), 32'(idx >= SB));
                    pos = idx % SB;
                    if (pos >= 1 && pos <= DW)
                        sdata = (idx >= SB) ? cr[DW-pos] : cl[DW-pos];
                    else
                        sdata = 1'($urandom);
                end
                prev_b = bclk_o;
            end
        end
    end

    initial begin : main
        fl[0] = 16'hA5C3; fr[0] = 16'h1234;
        fl[1] = 16'h8000; fr[1] = 16'h7FFF;
        fl[2] = 16'h1111; fr[2] = 16'h2222;
        fl[3] = 16'h3333; fr[3] = 16'h4444;
        for (int i = 4; i < NF; i++) begin
            fl[i] = 16'($urandom);
            fr[i] = 16'($urandom);
        end
        rst_n = 1'b1; en = 1'b0; ack = 1'b0; ovr_clr = 1'b0;

        // Power-on reset, then idle with en low.
        #2 rst_n = 1'b0;
        #1;
        chk("por_bclk",  32'(bclk_o),  0);
        chk("por_lrclk", 32'(lrclk_o), 0);
        chk("por_valid", 32'(valid_o), 0);
        chk("por_ovr",   32'(ovr_o),   0);
        chk("por_left",  32'(left_o),  0);
        chk("por_right", 32'(right_o), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_bclk", 32'(bclk_o), 0);
        end
        chk("idle_lrclk", 32'(lrclk_o), 0);
        chk("idle_valid", 32'(valid_o), 0);

        // Basic frame: waveform checked every cycle until completion.
        en = 1'b1;
        cyc = 0;
        for (int c = 1; c < 388; c++) begin
            step();
            chk("bclk_wave",  32'(bclk_o),  32'(exp_bclk(c)));
            chk("lrclk_wave", 32'(lrclk_o), 32'(exp_lrclk(c)));
        end
        chk("f0_early_valid", 32'(valid_o), 0);
        goto_cyc(388);
        chk_frame("f0", 0, 1'b1, 1'b0);

        // Handshake: one-cycle ack drops valid next cycle.
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_valid_low", 32'(valid_o), 0);
        goto_cyc(899);
        chk("f1_early_valid", 32'(valid_o), 0);
        goto_cyc(900);
        chk_frame("f1", 1, 1'b1, 1'b0);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // Overrun: two unacked frames, newest wins.
        goto_cyc(1412);
        chk_frame("f2", 2, 1'b1, 1'b0);
        goto_cyc(1924);
        chk_frame("f3_ovr", 3, 1'b1, 1'b1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_cleared", 32'(ovr_o), 0);
        chk("ovr_clr_valid", 32'(valid_o), 1);

        // Ack on the frame-complete edge: valid stays, no overrun.
        goto_cyc(2435);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_frame("f4_coinc_ack", 4, 1'b1, 1'b0);

        // ovr_clr on a new-overrun edge: set wins.
        goto_cyc(2947);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk_frame("f5_coinc_clr", 5, 1'b1, 1'b1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("f5_acked", 32'(valid_o), 0);

        // Abort during right slot pos 10 of frame 6 (bclk high there).
        goto_cyc(3412);
        chk("abort_pre_bclk",  32'(bclk_o),  1);
        chk("abort_pre_lrclk", 32'(lrclk_o), 1);
        en = 1'b0;
        step();
        chk("abort_bclk",  32'(bclk_o),  0);
        chk("abort_lrclk", 32'(lrclk_o), 0);
        for (int i = 0; i < 600; i++) step();
        chk("abort_idle_bclk", 32'(bclk_o), 0);
        chk_frame("abort_hold", 5, 1'b0, 1'b1);

        // Restart: next table frame completes cleanly at +388.
        en = 1'b1;
        cyc = 0;
        goto_cyc(387);
        chk("rs_early_valid", 32'(valid_o), 0);
        goto_cyc(388);
        chk_frame("rs_f7", 7, 1'b1, 1'b1);

        // Mid-frame asynchronous reset: outputs clear before any clk edge.
        goto_cyc(500);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_bclk",  32'(bclk_o),  0);
        chk("mrst_lrclk", 32'(lrclk_o), 0);
        chk("mrst_valid", 32'(valid_o), 0);
        chk("mrst_ovr",   32'(ovr_o),   0);
        chk("mrst_left",  32'(left_o),  0);
        chk("mrst_right", 32'(right_o), 0);
        en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("post_rst_bclk", 32'(bclk_o), 0);
        end
        chk("post_rst_lrclk", 32'(lrclk_o), 0);
        chk("post_rst_valid", 32'(valid_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
